// File: rtl/vec3_alu_pipe.sv
// Three-stage fixed-point 3-vector ALU (add, sub, scale, dot, cross) with valid/ready
// handshakes, a global stall enable and per-lane saturate-or-wrap narrowing.
module vec3_alu_pipe #(
    parameter int WIDTH  = 32,
    parameter int Q_BITS = 10,
    parameter bit SAT    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [3*WIDTH-1:0]   x,
    input  logic [3*WIDTH-1:0]   y,
    input  logic [WIDTH-1:0]     a,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3*WIDTH-1:0]   out,
    output logic [2:0]           ovf,
    output logic                 err
);
    localparam int PW = 2 * WIDTH;
    localparam int RW = 2 * WIDTH + 2;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_SCALE = 3'd2;
    localparam logic [2:0] OP_DOT   = 3'd3;
    localparam logic [2:0] OP_CROSS = 3'd4;

    logic                    en;
    logic signed [WIDTH-1:0] x_lane [3];
    logic signed [WIDTH-1:0] y_lane [3];
    logic signed [WIDTH-1:0] a_s;

    logic signed [PW-1:0]    p_next   [6];
    logic signed [PW-1:0]    s1_p_reg [6];
    logic [2:0]              s1_op_reg;
    logic                    s1_valid_reg;

    logic signed [RW-1:0]    r_next   [3];
    logic signed [RW-1:0]    s2_r_reg [3];
    logic                    s2_err_next;
    logic                    s2_err_reg;
    logic                    s2_valid_reg;

    logic [WIDTH-1:0]        lane_next [3];
    logic [2:0]              ovf_next;
    logic                    s3_valid_reg;
    logic [3*WIDTH-1:0]      out_reg;
    logic [2:0]              ovf_reg;
    logic                    err_reg;

    // Reset forces readiness so the upstream never sees a stall during reset.
    assign en       = !s3_valid_reg || out_ready;
    assign in_ready = en || rst;
    assign a_s      = a;

    assign out_valid = s3_valid_reg;
    assign out       = out_reg;
    assign ovf       = ovf_reg;
    assign err       = err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic fits;
            assign x_lane[gi] = x[gi*WIDTH +: WIDTH];
            assign y_lane[gi] = y[gi*WIDTH +: WIDTH];
            // A value fits when every bit above the WIDTH-bit sign bit repeats it.
            assign fits = (&s2_r_reg[gi][RW-1:WIDTH-1]) || !(|s2_r_reg[gi][RW-1:WIDTH-1]);
            assign ovf_next[gi] = !fits;
            if (SAT) begin : g_sat
                assign lane_next[gi] = fits ? s2_r_reg[gi][WIDTH-1:0] :
                                       (s2_r_reg[gi][RW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                           : {1'b0, {(WIDTH-1){1'b1}}});
            end else begin : g_wrap
                assign lane_next[gi] = s2_r_reg[gi][WIDTH-1:0];
            end
        end
    endgenerate

    // Stage 1 operands: lanes 0..2 hold sums or products, 3..5 hold the cross subtrahends.
    always_comb begin
        for (int i = 0; i < 6; i++) p_next[i] = '0;
        case (op)
            OP_ADD:   for (int i = 0; i < 3; i++) p_next[i] = PW'(x_lane[i]) + PW'(y_lane[i]);
            OP_SUB:   for (int i = 0; i < 3; i++) p_next[i] = PW'(x_lane[i]) - PW'(y_lane[i]);
            OP_SCALE: for (int i = 0; i < 3; i++) p_next[i] = PW'(x_lane[i]) * PW'(a_s);
            OP_DOT:   for (int i = 0; i < 3; i++) p_next[i] = PW'(x_lane[i]) * PW'(y_lane[i]);
            OP_CROSS: begin
                p_next[0] = PW'(x_lane[1]) * PW'(y_lane[2]);
                p_next[3] = PW'(x_lane[2]) * PW'(y_lane[1]);
                p_next[1] = PW'(x_lane[2]) * PW'(y_lane[0]);
                p_next[4] = PW'(x_lane[0]) * PW'(y_lane[2]);
                p_next[2] = PW'(x_lane[0]) * PW'(y_lane[1]);
                p_next[5] = PW'(x_lane[1]) * PW'(y_lane[0]);
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 3; i++) r_next[i] = '0;
        s2_err_next = 1'b0;
        case (s1_op_reg)
            OP_ADD, OP_SUB: for (int i = 0; i < 3; i++) r_next[i] = RW'(s1_p_reg[i]);
            OP_SCALE: for (int i = 0; i < 3; i++) r_next[i] = RW'(s1_p_reg[i] >>> Q_BITS);
            OP_DOT: r_next[0] = RW'(s1_p_reg[0] >>> Q_BITS) + RW'(s1_p_reg[1] >>> Q_BITS)
                              + RW'(s1_p_reg[2] >>> Q_BITS);
            OP_CROSS: for (int i = 0; i < 3; i++)
                r_next[i] = (RW'(s1_p_reg[i]) - RW'(s1_p_reg[i+3])) >>> Q_BITS;
            default: s2_err_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= '0;
            for (int i = 0; i < 6; i++) s1_p_reg[i] <= '0;
            s2_valid_reg <= 1'b0;
            s2_err_reg   <= 1'b0;
            for (int i = 0; i < 3; i++) s2_r_reg[i] <= '0;
            s3_valid_reg <= 1'b0;
            out_reg      <= '0;
            ovf_reg      <= '0;
            err_reg      <= 1'b0;
        end else if (en) begin
            s1_valid_reg <= in_valid;
            s1_op_reg    <= op;
            for (int i = 0; i < 6; i++) s1_p_reg[i] <= p_next[i];
            s2_valid_reg <= s1_valid_reg;
            s2_err_reg   <= s2_err_next;
            for (int i = 0; i < 3; i++) s2_r_reg[i] <= r_next[i];
            s3_valid_reg <= s2_valid_reg;
            // Bubbles leave the last result on the outputs.
            if (s2_valid_reg) begin
                out_reg <= {lane_next[2], lane_next[1], lane_next[0]};
                ovf_reg <= ovf_next;
                err_reg <= s2_err_reg;
            end
        end
    end
endmodule
